// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package rv_fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  // Bytes per instruction bus word.
  localparam int FETCH_WORD_BYTES = 4;

endpackage

// File: rtl/rv_fetch_ctrl_add.sv
// Plain ripple adder with carry in/out, used for the fetch word-address increment.
module add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // Widen by one bit so the carry out falls out of the same addition.
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_carry};

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Instruction fetch controller: issues word requests, pushes returned
// halfwords into the fetch buffer, and handles redirects by resetting the
// buffer and discarding any response still owed by the bus.
module rv_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int                          IADDR_SPACE_BITS = 16,
  parameter logic [IADDR_SPACE_BITS-1:0] RESET_PC         = '0
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_flush,
  input  logic [IADDR_SPACE_BITS-2:0]   i_flush_pc,
  output logic                          o_instr_req,
  output logic [IADDR_SPACE_BITS-3:0]   o_instr_addr,
  input  logic                          i_instr_ack,
  input  logic                          i_instr_valid,
  input  logic [31:0]                   i_instr_data,
  output logic                          o_buf_reset_n,
  output logic [IADDR_SPACE_BITS-2:0]   o_buf_pc,
  output logic [15:0]                   o_data_lo,
  output logic [15:0]                   o_data_hi,
  output logic                          o_push_single,
  output logic                          o_push_double,
  input  logic                          i_buf_full
);

  localparam int PCW = IADDR_SPACE_BITS - 1;   // halfword PC width
  localparam int AW  = IADDR_SPACE_BITS - 2;   // word address width
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]         rst_sync;
  logic               rst_n;

  fetch_state_t       state, state_nxt;
  logic [PCW-1:0]     pc, pc_nxt;
  logic [AW-1:0]      addr, addr_nxt, addr_inc;
  logic               odd_start, odd_start_nxt;
  logic               buf_reset_n, buf_reset_n_nxt;
  logic               push_single, push_single_nxt;
  logic               push_double, push_double_nxt;
  logic [15:0]        data_lo, data_lo_nxt;
  logic [15:0]        data_hi, data_hi_nxt;
  logic               req;
  logic               accept;

  // Reset synchronizer: assertion is immediate, release is aligned to the clock.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Request is the only combinational output so buffer-full backpressure acts in the same cycle.
  assign req    = (state == ST_REQ) && !i_buf_full;
  assign accept = req && i_instr_ack;

  add #(
    .WIDTH (AW)
  ) u_addr_inc (
    .i_a     (addr),
    .i_b     (ADDR_ONE),
    .i_carry (1'b0),
    .o_sum   (addr_inc),
    .o_carry ()
  );

  // Next-state, PC/address update and push decode.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    addr_nxt        = addr;
    odd_start_nxt   = odd_start;
    push_single_nxt = 1'b0;
    push_double_nxt = 1'b0;
    data_lo_nxt     = data_lo;
    data_hi_nxt     = data_hi;

    if (i_flush) begin
      pc_nxt   = i_flush_pc;
      addr_nxt = i_flush_pc[PCW-1:1];
      // A redirect goes straight to SYNC unless a bus response is still owed,
      // in which case DROP waits it out so it never reaches the new stream.
      case (state)
        ST_SYNC: state_nxt = ST_SYNC;
        ST_REQ:  state_nxt = accept ? ST_DROP : ST_SYNC;
        ST_WAIT: state_nxt = i_instr_valid ? ST_SYNC : ST_DROP;
        ST_DROP: state_nxt = i_instr_valid ? ST_SYNC : ST_DROP;
        default: state_nxt = ST_SYNC;
      endcase
    end else begin
      case (state)
        ST_SYNC: begin
          // An odd halfword start means the first word only carries its upper half.
          odd_start_nxt = pc[0];
          addr_nxt      = pc[PCW-1:1];
          state_nxt     = ST_REQ;
        end
        ST_REQ: begin
          if (accept) begin
            addr_nxt  = addr_inc;
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_instr_valid) begin
            data_hi_nxt = i_instr_data[31:16];
            if (odd_start) begin
              push_single_nxt = 1'b1;
            end else begin
              push_double_nxt = 1'b1;
              data_lo_nxt     = i_instr_data[15:0];
            end
            odd_start_nxt = 1'b0;
            state_nxt     = ST_REQ;
          end
        end
        ST_DROP: begin
          if (i_instr_valid) state_nxt = ST_SYNC;
        end
        default: state_nxt = ST_SYNC;
      endcase
    end

    buf_reset_n_nxt = !((state_nxt == ST_SYNC) || (state_nxt == ST_DROP));
  end

  // State, PC, address and registered buffer-side outputs.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SYNC;
      pc          <= RESET_PC[IADDR_SPACE_BITS-1:1];
      addr        <= RESET_PC[IADDR_SPACE_BITS-1:2];
      odd_start   <= RESET_PC[1];
      buf_reset_n <= 1'b0;
      push_single <= 1'b0;
      push_double <= 1'b0;
      data_lo     <= '0;
      data_hi     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      addr        <= addr_nxt;
      odd_start   <= odd_start_nxt;
      buf_reset_n <= buf_reset_n_nxt;
      push_single <= push_single_nxt;
      push_double <= push_double_nxt;
      data_lo     <= data_lo_nxt;
      data_hi     <= data_hi_nxt;
    end
  end

  assign o_instr_req   = req;
  assign o_instr_addr  = addr;
  assign o_buf_reset_n = buf_reset_n;
  assign o_buf_pc      = pc;
  assign o_data_lo     = data_lo;
  assign o_data_hi     = data_hi;
  assign o_push_single = push_single;
  assign o_push_double = push_double;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Testbench for rv_fetch_ctrl: directed cycle table, reset corner cases and a
// randomized bus/flush run checked against a transaction-level model.
module tb_rv_fetch_ctrl;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_flush;
  logic [14:0] i_flush_pc;
  logic        o_instr_req;
  logic [13:0] o_instr_addr;
  logic        i_instr_ack;
  logic        i_instr_valid;
  logic [31:0] i_instr_data;
  logic        o_buf_reset_n;
  logic [14:0] o_buf_pc;
  logic [15:0] o_data_lo;
  logic [15:0] o_data_hi;
  logic        o_push_single;
  logic        o_push_double;
  logic        i_buf_full;

  rv_fetch_ctrl #(
    .IADDR_SPACE_BITS (16),
    .RESET_PC         (16'h0100)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_flush       (i_flush),
    .i_flush_pc    (i_flush_pc),
    .o_instr_req   (o_instr_req),
    .o_instr_addr  (o_instr_addr),
    .i_instr_ack   (i_instr_ack),
    .i_instr_valid (i_instr_valid),
    .i_instr_data  (i_instr_data),
    .o_buf_reset_n (o_buf_reset_n),
    .o_buf_pc      (o_buf_pc),
    .o_data_lo     (o_data_lo),
    .o_data_hi     (o_data_hi),
    .o_push_single (o_push_single),
    .o_push_double (o_push_double),
    .i_buf_full    (i_buf_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        fl;
    logic [14:0] fpc;
    logic        full;
    logic        ack;
    logic        vld;
    logic [31:0] data;
    logic        req;
    logic [13:0] addr;
    logic        brn;
    logic [14:0] bpc;
    logic        ps;
    logic        pd;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic [14:0] fpc, input logic full, input logic ack,
                              input logic vld, input logic [31:0] data, input logic req, input logic [13:0] addr,
                              input logic brn, input logic [14:0] bpc, input logic ps, input logic pd,
                              input logic [15:0] lo, input logic [15:0] hi);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.full = full; v.ack = ack; v.vld = vld; v.data = data;
    v.req = req; v.addr = addr; v.brn = brn; v.bpc = bpc; v.ps = ps; v.pd = pd; v.lo = lo; v.hi = hi;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_flush       = 1'b0;
    i_flush_pc    = '0;
    i_instr_ack   = 1'b0;
    i_instr_valid = 1'b0;
    i_instr_data  = '0;
    i_buf_full    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},    {31'd0, o_instr_req},   32'd0);
    chk({tag, "_addr"},   {18'd0, o_instr_addr},  32'h040);
    chk({tag, "_brn"},    {31'd0, o_buf_reset_n}, 32'd0);
    chk({tag, "_bpc"},    {17'd0, o_buf_pc},      32'h080);
    chk({tag, "_push"},   {30'd0, o_push_single, o_push_double}, 32'd0);
    chk({tag, "_data"},   {o_data_hi, o_data_lo}, 32'd0);
  endtask

  // Bounded wait for the buffer to leave reset, i.e. the controller reaching ST_REQ.
  task automatic wait_running(input string tag);
    int n;
    n = 0;
    while (o_buf_reset_n !== 1'b1 && n < 10) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, o_buf_reset_n}, 32'd1);
  endtask

  // Transaction-level reference model state for the random run.
  logic [13:0] m_addr;
  logic        m_odd;
  logic        m_pending;
  logic        m_stale;
  logic        e_ps, e_pd;
  logic [15:0] e_lo, e_hi;
  int          n_push;
  logic        bus_pend;
  int          bus_cnt;

  initial begin
    idle_inputs();
    i_reset_n = 1'b1;
    #2 i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_reset_n = 1'b1;
    wait_running("reset_release");

    // Cycle table: {fl, fpc, full, ack, vld, data, | req, addr, brn, bpc, ps, pd, lo, hi}
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h040, 1, 15'h080, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 1, 32'h00138513, 0, 14'h041, 1, 15'h080, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 15'h00C1, 0, 0, 0, 32'h0,        1, 14'h041, 1, 15'h080, 0, 1, 16'h8513, 16'h0013));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 0, 32'h0,        0, 14'h060, 0, 15'h0C1, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h060, 1, 15'h0C1, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 1, 32'hABCD1234, 0, 14'h061, 1, 15'h0C1, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h061, 1, 15'h0C1, 1, 0, 16'h0,    16'hABCD));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 1, 32'hCAFEF00D, 0, 14'h062, 1, 15'h0C1, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 1, 0, 0, 32'h0,        0, 14'h062, 1, 15'h0C1, 0, 1, 16'hF00D, 16'hCAFE));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 15'h0000, 1, 0, 0, 32'h0,      0, 14'h062, 1, 15'h0C1, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h062, 1, 15'h0C1, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 15'h0010, 0, 0, 0, 32'h0,        0, 14'h063, 1, 15'h0C1, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 0, 32'h0,        0, 14'h008, 0, 15'h010, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 0, 32'h0,        0, 14'h008, 0, 15'h010, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 1, 32'hDEADBEEF, 0, 14'h008, 0, 15'h010, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 0, 32'h0,        0, 14'h008, 0, 15'h010, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h008, 1, 15'h010, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 15'h0021, 0, 0, 1, 32'h11112222, 0, 14'h009, 1, 15'h010, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 0, 32'h0,        0, 14'h010, 0, 15'h021, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h010, 1, 15'h021, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 15'h0044, 0, 0, 0, 32'h0,        0, 14'h011, 1, 15'h021, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 15'h00A2, 0, 0, 0, 32'h0,        0, 14'h022, 0, 15'h044, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 1, 32'h12345678, 0, 14'h051, 0, 15'h0A2, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 0, 32'h0,        0, 14'h051, 0, 15'h0A2, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h051, 1, 15'h0A2, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 1, 32'h55667788, 0, 14'h052, 1, 15'h0A2, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 15'h7FFE, 0, 0, 0, 32'h0,        1, 14'h052, 1, 15'h0A2, 0, 1, 16'h7788, 16'h5566));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 0, 32'h0,        0, 14'h3FFF, 0, 15'h7FFE, 0, 0, 16'h0,  16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h3FFF, 1, 15'h7FFE, 0, 0, 16'h0,  16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 0, 1, 32'h0BADCAFE, 0, 14'h0000, 1, 15'h7FFE, 0, 0, 16'h0,  16'h0));
    vecs.push_back(mk(0, 15'h0000, 0, 1, 0, 32'h0,        1, 14'h0000, 1, 15'h7FFE, 0, 1, 16'hCAFE, 16'h0BAD));

    foreach (vecs[i]) begin
      i_flush       = vecs[i].fl;
      i_flush_pc    = vecs[i].fpc;
      i_buf_full    = vecs[i].full;
      i_instr_ack   = vecs[i].ack;
      i_instr_valid = vecs[i].vld;
      i_instr_data  = vecs[i].data;
      #1;
      chk($sformatf("row%0d_req", i),  {31'd0, o_instr_req},   {31'd0, vecs[i].req});
      chk($sformatf("row%0d_addr", i), {18'd0, o_instr_addr},  {18'd0, vecs[i].addr});
      chk($sformatf("row%0d_brn", i),  {31'd0, o_buf_reset_n}, {31'd0, vecs[i].brn});
      chk($sformatf("row%0d_bpc", i),  {17'd0, o_buf_pc},      {17'd0, vecs[i].bpc});
      chk($sformatf("row%0d_push", i), {30'd0, o_push_single, o_push_double}, {30'd0, vecs[i].ps, vecs[i].pd});
      if (vecs[i].ps || vecs[i].pd)
        chk($sformatf("row%0d_hi", i), {16'd0, o_data_hi}, {16'd0, vecs[i].hi});
      if (vecs[i].pd)
        chk($sformatf("row%0d_lo", i), {16'd0, o_data_lo}, {16'd0, vecs[i].lo});
      @(posedge i_clk); #1;
    end

    // Controller is now waiting on the response for word 0x0000; reset must act without a clock edge.
    idle_inputs();
    i_reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    wait_running("reset2_release");

    // Randomized run against the transaction-level model.
    m_addr = 14'h040; m_odd = 1'b0; m_pending = 1'b0; m_stale = 1'b0;
    e_ps = 1'b0; e_pd = 1'b0; e_lo = '0; e_hi = '0;
    n_push = 0; bus_pend = 1'b0; bus_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acc;
      logic [13:0] seen_addr;
      chk("rnd_push", {30'd0, o_push_single, o_push_double}, {30'd0, e_ps, e_pd});
      if (e_ps || e_pd) chk("rnd_hi", {16'd0, o_data_hi}, {16'd0, e_hi});
      if (e_pd)         chk("rnd_lo", {16'd0, o_data_lo}, {16'd0, e_lo});

      i_buf_full    = ($urandom_range(0, 9) < 2);
      i_flush       = ($urandom_range(0, 99) < 5);
      i_flush_pc    = 15'($urandom);
      i_instr_ack   = 1'b0;
      i_instr_valid = 1'b0;
      i_instr_data  = $urandom;
      if (bus_pend) begin
        if (bus_cnt == 0) begin
          i_instr_valid = 1'b1;
          bus_pend      = 1'b0;
        end else begin
          bus_cnt--;
        end
      end
      #1;
      if (m_pending || i_buf_full) chk("rnd_req_blocked", {31'd0, o_instr_req}, 32'd0);
      i_instr_ack = o_instr_req && ($urandom_range(0, 9) < 7);
      acc = o_instr_req && i_instr_ack;
      seen_addr = o_instr_addr;
      if (acc) begin
        bus_pend = 1'b1;
        bus_cnt  = $urandom_range(0, 2);
      end

      e_ps = 1'b0; e_pd = 1'b0;
      if (acc) chk("rnd_addr", {18'd0, seen_addr}, {18'd0, m_addr});
      if (i_flush) begin
        m_addr = i_flush_pc[14:1];
        m_odd  = i_flush_pc[0];
        if (i_instr_valid) m_pending = 1'b0;
        if (acc) m_pending = 1'b1;
        m_stale = m_pending;
      end else begin
        if (i_instr_valid) begin
          if (!m_stale) begin
            e_hi = i_instr_data[31:16];
            if (m_odd) begin
              e_ps = 1'b1;
            end else begin
              e_pd = 1'b1;
              e_lo = i_instr_data[15:0];
            end
            m_odd = 1'b0;
            n_push++;
          end
          m_pending = 1'b0;
          m_stale   = 1'b0;
        end
        if (acc) begin
          m_addr    = m_addr + 14'd1;
          m_pending = 1'b1;
          m_stale   = 1'b0;
        end
      end
      @(posedge i_clk); #1;
    end
    chk("rnd_push_final", {30'd0, o_push_single, o_push_double}, {30'd0, e_ps, e_pd});
    chk("rnd_progress", {31'd0, (n_push >= 100)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv_fetch_ctrl.md
# rv_fetch_ctrl

Instruction fetch controller: the writer side of the fetch buffer. Issues word-aligned requests on the instruction bus, pushes returned halfwords into the fetch buffer as single (odd-halfword entry) or double pushes, throttles on buffer full, and on a redirect resets the buffer, loads its PC and discards any in-flight response.

## Interface
- IADDR_SPACE_BITS, 16: instruction address width in bits; byte address.
- RESET_PC, 0: fetch PC after reset; bit 0 ignored.
- i_clk  in  1: clock.
- i_reset_n  in  1: one clock; reset is asynchronous and active-low.
- i_flush  in  1: redirect pulse; takes priority over all other events.
- i_flush_pc  in  IADDR_SPACE_BITS-1: new halfword PC, bits [IADDR_SPACE_BITS-1:1].
- o_instr_req  out  1: bus request valid.
- o_instr_addr  out  IADDR_SPACE_BITS-2: word address, bits [IADDR_SPACE_BITS-1:2].
- i_instr_ack  in  1: request accepted this cycle.
- i_instr_valid  in  1: response data valid, one cycle per accepted request.
- i_instr_data  in  32: response word.
- o_buf_reset_n  out  1: fetch buffer synchronous reset, active-low.
- o_buf_pc  out  IADDR_SPACE_BITS-1: PC loaded by the buffer while o_buf_reset_n=0.
- o_data_lo, o_data_hi  out  16 each: halfwords to the buffer.
- o_push_single, o_push_double  out  1 each: buffer push strobes; never both high.
- i_buf_full  in  1: buffer has fewer than 2 free halfword slots beyond any pending push.

## Operation
- States (fetch_state_t): ST_SYNC, ST_REQ, ST_WAIT, ST_DROP.
- ST_SYNC: o_buf_reset_n=0, o_buf_pc=fetch PC; lasts exactly one cycle, then ST_REQ.
- ST_REQ: o_instr_req=!i_buf_full. On req&ack: advance word address by 1 (wraps modulo 2^(IADDR_SPACE_BITS-2)), go ST_WAIT.
- ST_WAIT: on i_instr_valid, register push, go ST_REQ.
  - First response after ST_SYNC with fetch PC[1]=1: o_push_single, o_data_hi=data[31:16].
  - Otherwise: o_push_double, o_data_lo=data[15:0], o_data_hi=data[31:16].
- i_flush in ST_REQ or ST_SYNC (no response owed): load i_flush_pc, go ST_SYNC.
- i_flush in ST_WAIT without i_instr_valid, or in ST_REQ with req&ack same cycle: load PC, go ST_DROP.
- i_flush in ST_WAIT with i_instr_valid same cycle: response dropped (no push), go ST_SYNC.
- ST_DROP: o_instr_req=0; o_buf_reset_n=0 held; on i_instr_valid go ST_SYNC, no push. Further i_flush reloads PC, stays ST_DROP.
- At most one request outstanding; guarantees a push always fits once issued with i_buf_full=0.
- Push strobes are suppressed in any cycle where o_buf_reset_n=0 or a flush is taken.

## Timing
- Reset (async assert, sync deassert internally): state ST_SYNC, fetch PC=RESET_PC, o_instr_req=0, o_instr_addr=RESET_PC[IADDR_SPACE_BITS-1:2], o_buf_reset_n=0, o_buf_pc=RESET_PC[IADDR_SPACE_BITS-1:1], o_push_*=0, o_data_*=0.
- All outputs registered except o_instr_req (state & !i_buf_full).
- o_instr_addr stable while o_instr_req=1 and ack not seen; request may drop if i_buf_full rises before ack.
- Push strobe one cycle after i_instr_valid; single-cycle pulse.
- Flush to first request: 2 cycles (flush edge, ST_SYNC, request); longer if in ST_DROP.
- Steady state: one word per 2 cycles with zero-wait bus (ack with req, valid next cycle).
- Reset mid-transaction: outstanding response is the bus's responsibility; block restarts in ST_SYNC.

## Structure
- rv_fetch_pkg: fetch_state_t enum, FETCH_WORD_BYTES=4 constant.
- Word-address increment uses the existing add sub-module (WIDTH=IADDR_SPACE_BITS-2, i_carry=0, o_carry unconnected).
- Single always_ff with async reset for state, PC, outputs; combinational next-state block.

## Test plan
- Reset, RESET_PC=0x0100, zero-wait bus returning 0x00138513 -> one cycle o_buf_reset_n=0 with o_buf_pc=0x080, request addr 0x040, o_push_double with lo=0x8513, hi=0x0013.
- i_flush with i_flush_pc=0x0C1 (byte 0x182) -> o_buf_pc=0x0C1, request addr 0x060, first response 0xABCD1234 gives o_push_single, o_data_hi=0xABCD; next request addr 0x061 gives push_double.
- i_buf_full=1 held 5 cycles in ST_REQ -> o_instr_req=0 throughout, no pushes; deassert -> request next cycle at unchanged address.
- Flush while ST_WAIT, response returned 3 cycles later -> no push from stale response, o_buf_reset_n low until it arrives, new request at flush address next.
- Flush same cycle as i_instr_valid -> no push, ST_SYNC next; second flush during ST_DROP -> last i_flush_pc wins.
- Address at 0x3FFF word with IADDR_SPACE_BITS=16 -> next request wraps to 0x0000; async reset asserted mid-ST_WAIT -> all outputs at reset values immediately.
